// File: rtl/kmeans_pkg.sv
// rtl/kmeans_pkg.sv - shared cluster addresses, FSM state type and default widths
package kmeans_pkg;
  localparam int DIST_W  = 32;
  localparam int COORD_W = 16;

  localparam logic [1:0] CL0 = 2'b00;
  localparam logic [1:0] CL1 = 2'b01;
  localparam logic [1:0] CL2 = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/lta_argmin3.sv
// rtl/lta_argmin3.sv - combinational three-way argmin; ties resolve to the lowest index
module lta_argmin3
  import kmeans_pkg::*;
#(
  parameter int W = kmeans_pkg::DIST_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [1:0]   addr
);
  always_comb begin
    if (a <= b && a <= c) addr = CL0;
    else if (b <= c)      addr = CL1;
    else                  addr = CL2;
  end
endmodule

// File: rtl/kmeans_assign_ctrl.sv
// rtl/kmeans_assign_ctrl.sv - per-iteration nearest-cluster assignment with count/sum accumulation
module kmeans_assign_ctrl
  import kmeans_pkg::*;
#(
  parameter int DIST_W  = kmeans_pkg::DIST_W,
  parameter int COORD_W = kmeans_pkg::COORD_W,
  parameter int CNT_W   = 16,
  parameter int SUM_W   = COORD_W + CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_points,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIST_W-1:0]  dist1,
  input  logic [DIST_W-1:0]  dist2,
  input  logic [DIST_W-1:0]  dist3,
  input  logic [COORD_W-1:0] point_x,
  input  logic [COORD_W-1:0] point_y,
  output logic               assign_valid,
  output logic [1:0]         assign_addr,
  output logic               busy,
  output logic               done,
  input  logic [1:0]         rd_sel,
  output logic [CNT_W-1:0]   rd_count,
  output logic [SUM_W-1:0]   rd_sum_x,
  output logic [SUM_W-1:0]   rd_sum_y
);
  state_t state, state_next;

  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   beat_cnt;
  logic               stg_valid;
  logic [DIST_W-1:0]  stg_d1, stg_d2, stg_d3;
  logic [COORD_W-1:0] stg_x, stg_y;
  logic [1:0]         win;
  logic [CNT_W-1:0]   count_q [3];
  logic [SUM_W-1:0]   sum_x_q [3];
  logic [SUM_W-1:0]   sum_y_q [3];
  logic               start_ok;
  logic               accept;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (num_points == '0) ? DONE : RUN;
      RUN:        if (beat_cnt == num_q) state_next = DRAIN;
      DRAIN:      state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
    in_ready = (state == RUN) && (beat_cnt != num_q);
  end

  lta_argmin3 #(.W(DIST_W)) u_argmin (
    .a    (stg_d1),
    .b    (stg_d2),
    .c    (stg_d3),
    .addr (win)
  );

  // Stage capture at E and accumulation at E+1 overlap, so beats stream one per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_q        <= '0;
      beat_cnt     <= '0;
      stg_valid    <= 1'b0;
      stg_d1       <= '0;
      stg_d2       <= '0;
      stg_d3       <= '0;
      stg_x        <= '0;
      stg_y        <= '0;
      assign_valid <= 1'b0;
      assign_addr  <= '0;
      for (int k = 0; k < 3; k++) begin
        count_q[k] <= '0;
        sum_x_q[k] <= '0;
        sum_y_q[k] <= '0;
      end
    end else begin
      stg_valid    <= accept;
      assign_valid <= stg_valid;
      if (accept) begin
        stg_d1 <= dist1;
        stg_d2 <= dist2;
        stg_d3 <= dist3;
        stg_x  <= point_x;
        stg_y  <= point_y;
      end
      if (stg_valid) assign_addr <= win;
      if (start_ok) begin
        num_q    <= num_points;
        beat_cnt <= '0;
        for (int k = 0; k < 3; k++) begin
          count_q[k] <= '0;
          sum_x_q[k] <= '0;
          sum_y_q[k] <= '0;
        end
      end else begin
        if (accept) beat_cnt <= beat_cnt + CNT_W'(1);
        for (int k = 0; k < 3; k++) begin
          if (stg_valid && win == 2'(k)) begin
            count_q[k] <= count_q[k] + CNT_W'(1);
            sum_x_q[k] <= sum_x_q[k] + SUM_W'(stg_x);
            sum_y_q[k] <= sum_y_q[k] + SUM_W'(stg_y);
          end
        end
      end
    end
  end

  always_comb begin
    rd_count = '0;
    rd_sum_x = '0;
    rd_sum_y = '0;
    case (rd_sel)
      CL0: begin rd_count = count_q[0]; rd_sum_x = sum_x_q[0]; rd_sum_y = sum_y_q[0]; end
      CL1: begin rd_count = count_q[1]; rd_sum_x = sum_x_q[1]; rd_sum_y = sum_y_q[1]; end
      CL2: begin rd_count = count_q[2]; rd_sum_x = sum_x_q[2]; rd_sum_y = sum_y_q[2]; end
      default: ;
    endcase
  end
endmodule
